alocador_ativos: RTL and testbench
==================================

# alocador_ativos

- Owns the pool of `NUM_NA` active-node slots.
- Each slot holds a node address and an active flag.
- Drives the `na_endereco`/`na_ativo` bus that feeds `gerenciador_ativos`, which then derives its `habilitar` vector from that bus.
- Upstream search logic inserts newly discovered node addresses and removes nodes once they are expanded; the block allocates, de-duplicates and frees slots and reports occupancy.

## Interface

- `NUM_NA`, 8: number of slots; must be ≥ 2.
- `ADR_WIDTH`, 5: node address width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `limpar_in` input 1: synchronous clear of all slots.
- `inserir_in` input 1: insert request, one cycle per request.
- `endereco_in` input `ADR_WIDTH`: address to insert.
- `remover_in` input 1: remove request.
- `remover_endereco_in` input `ADR_WIDTH`: address to remove.
- `na_endereco_out` output `ADR_WIDTH*NUM_NA`: slot i address at bits `[i*ADR_WIDTH +: ADR_WIDTH]`.
- `na_ativo_out` output `NUM_NA`: bit i = slot i active.
- `livres_out` output `$clog2(NUM_NA+1)`: count of free slots.
- `cheio_out` output 1: no free slot.
- `vazio_out` output 1: no active slot.
- `inserido_out` output 1: one-cycle pulse, insert accepted.
- `slot_out` output `$clog2(NUM_NA)`: slot index used by the last accepted insert.
- `erro_out` output 1: one-cycle pulse, insert rejected (pool full or duplicate address).

## Operation

- All outputs are registered.
- Reset values:
  - `na_endereco_out` = 0, `na_ativo_out` = 0.
  - `livres_out` = `NUM_NA`, `vazio_out` = 1, `cheio_out` = 0.
  - `inserido_out` = 0, `erro_out` = 0, `slot_out` = 0.
- Priority per cycle: `limpar_in` > remove > insert.
- `limpar_in` = 1:
  - all `na_ativo` bits cleared, `livres` = `NUM_NA`.
  - addresses left unchanged; the insert and remove inputs are ignored.
  - no pulses.
- Remove:
  - Every active slot whose address equals `remover_endereco_in` is cleared; this is at most one slot, because duplicates are never stored.
  - The stored address is kept; only the active bit drops.
  - Removing an absent address is a silent no-op; `livres` is unchanged.
- Insert is evaluated against the state *after* the same-cycle removal:
  - Duplicate (address active after removal): reject, `erro_out` pulse, no state change.
  - Else no free slot: reject, `erro_out` pulse.
  - Else write `endereco_in` into the lowest-index free slot, set its active bit, set `slot_out` = that index, `inserido_out` pulse.
- Simultaneous remove and insert:
  - On a full pool, a hit removal frees a slot and the insert takes the lowest free index, which may be the slot just freed.
  - Same address on both ports: the address ends up active, re-inserted at the lowest free index.
- Counter update: `livres` += (remove hit) − (insert accepted), computed at full width.
  - It never underflows or overflows, because inserts are only accepted when a slot is free.
  - `cheio_out` = (`livres` == 0) and `vazio_out` = (`livres` == `NUM_NA`), both registered alongside `livres`.
- `slot_out` holds its value until the next accepted insert; it is cleared by `rst` only.
- Requirement: `livres_out` always equals `NUM_NA` − popcount(`na_ativo_out`).

## Timing

- Request sampled at rising edge N; slot contents, `livres_out`, `cheio_out`, `vazio_out`, `inserido_out`/`erro_out` and `slot_out` all valid after edge N (latency 1).
- Pulses last exactly one cycle. Back-to-back inserts are accepted every cycle.
- An insert at edge N+1 sees the result of the request at edge N, so back-to-back identical addresses give the second request `erro_out`.
- Asserting `rst` mid-sequence clears everything immediately, regardless of `clk`. The first request honoured is at the first rising edge after `rst` deasserts.
- No combinational path from any input to any output.

## Test plan

- Reset → `na_ativo_out` = 0, `livres_out` = 8, `vazio_out` = 1, `cheio_out` = 0, no pulses.
- Insert 5, 9, 12 on consecutive cycles:
  - slots 0/1/2 hold 5/9/12 with `na_ativo_out` = 8'b0000_0111.
  - `slot_out` 0, 1, 2 with an `inserido_out` pulse each.
  - `livres_out` = 5.
- Duplicate and free-slot reuse:
  - Insert 9 again → `erro_out` pulse, state unchanged.
  - Remove 9 → `na_ativo_out` = 8'b0000_0101, `livres_out` = 6.
  - Insert 20 → goes to slot 1.
- Full pool:
  - Fill 8 slots → `cheio_out` = 1, `livres_out` = 0.
  - A further insert → `erro_out` pulse.
  - Same-cycle remove of slot 3's address plus insert 31 → 31 in slot 3, `inserido_out` pulse, `cheio_out` stays 1.
- Priority:
  - `limpar_in` together with an insert → all inactive, `livres_out` = 8, no pulse.
  - Remove of an absent address → no change.
- Assert `rst` mid-burst of inserts → outputs return to their reset values at once; the first insert after deassert lands in slot 0.

Source files
------------

// File: rtl/alocador_ativos.sv
// Active-node slot pool: allocates, de-duplicates and frees node addresses and
// drives the registered address/active bus consumed by gerenciador_ativos.
module alocador_ativos #(
    parameter int NUM_NA    = 8,
    parameter int ADR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          limpar_in,
    input  logic                          inserir_in,
    input  logic [ADR_WIDTH-1:0]          endereco_in,
    input  logic                          remover_in,
    input  logic [ADR_WIDTH-1:0]          remover_endereco_in,
    output logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_out,
    output logic [NUM_NA-1:0]             na_ativo_out,
    output logic [$clog2(NUM_NA+1)-1:0]   livres_out,
    output logic                          cheio_out,
    output logic                          vazio_out,
    output logic                          inserido_out,
    output logic [$clog2(NUM_NA)-1:0]     slot_out,
    output logic                          erro_out
);

    localparam int LW = $clog2(NUM_NA + 1);
    localparam int SW = $clog2(NUM_NA);

    logic [ADR_WIDTH-1:0] enderecos [NUM_NA];
    logic [NUM_NA-1:0]    ativo;
    logic [LW-1:0]        livres;

    logic [NUM_NA-1:0]    acerto;
    logic [NUM_NA-1:0]    ativo_rem;
    logic [NUM_NA-1:0]    ativo_prox;
    logic                 duplicado;
    logic                 tem_livre;
    logic [SW-1:0]        livre_idx;
    logic                 aceito;
    logic                 rejeitado;
    logic [LW-1:0]        livres_prox;

    // Insert is judged against the pool as it looks after this cycle's removal.
    always_comb begin
        acerto     = '0;
        duplicado  = 1'b0;
        tem_livre  = 1'b0;
        livre_idx  = '0;
        for (int i = 0; i < NUM_NA; i++)
            acerto[i] = remover_in && ativo[i] && (enderecos[i] == remover_endereco_in);
        ativo_rem = ativo & ~acerto;
        for (int i = 0; i < NUM_NA; i++)
            if (ativo_rem[i] && (enderecos[i] == endereco_in))
                duplicado = 1'b1;
        for (int i = NUM_NA - 1; i >= 0; i--)
            if (!ativo_rem[i]) begin
                livre_idx = SW'(i);
                tem_livre = 1'b1;
            end
        aceito     = inserir_in && !duplicado && tem_livre;
        rejeitado  = inserir_in && !aceito;
        ativo_prox = ativo_rem;
        if (aceito)
            ativo_prox[livre_idx] = 1'b1;
        livres_prox = livres + LW'(|acerto) - LW'(aceito);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NA; i++)
                enderecos[i] <= '0;
            ativo        <= '0;
            livres       <= LW'(NUM_NA);
            cheio_out    <= 1'b0;
            vazio_out    <= 1'b1;
            inserido_out <= 1'b0;
            erro_out     <= 1'b0;
            slot_out     <= '0;
        end else if (limpar_in) begin
            ativo        <= '0;
            livres       <= LW'(NUM_NA);
            cheio_out    <= 1'b0;
            vazio_out    <= 1'b1;
            inserido_out <= 1'b0;
            erro_out     <= 1'b0;
        end else begin
            if (aceito) begin
                enderecos[livre_idx] <= endereco_in;
                slot_out             <= livre_idx;
            end
            ativo        <= ativo_prox;
            livres       <= livres_prox;
            cheio_out    <= (livres_prox == '0);
            vazio_out    <= (livres_prox == LW'(NUM_NA));
            inserido_out <= aceito;
            erro_out     <= rejeitado;
        end
    end

    always_comb begin
        na_endereco_out = '0;
        for (int i = 0; i < NUM_NA; i++)
            na_endereco_out[i*ADR_WIDTH +: ADR_WIDTH] = enderecos[i];
    end

    assign na_ativo_out = ativo;
    assign livres_out   = livres;

endmodule

// File: tb/tb_alocador_ativos.sv
// Directed bench for alocador_ativos: allocation, duplicates, full pool,
// clear/remove priority and asynchronous reset.
module tb_alocador_ativos;

    localparam int NUM_NA    = 8;
    localparam int ADR_WIDTH = 5;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        limpar_in;
    logic                        inserir_in;
    logic [ADR_WIDTH-1:0]        endereco_in;
    logic                        remover_in;
    logic [ADR_WIDTH-1:0]        remover_endereco_in;
    logic [ADR_WIDTH*NUM_NA-1:0] na_endereco_out;
    logic [NUM_NA-1:0]           na_ativo_out;
    logic [3:0]                  livres_out;
    logic                        cheio_out;
    logic                        vazio_out;
    logic                        inserido_out;
    logic [2:0]                  slot_out;
    logic                        erro_out;

    int checks = 0;
    int errors = 0;

    alocador_ativos #(.NUM_NA(NUM_NA), .ADR_WIDTH(ADR_WIDTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .limpar_in           (limpar_in),
        .inserir_in          (inserir_in),
        .endereco_in         (endereco_in),
        .remover_in          (remover_in),
        .remover_endereco_in (remover_endereco_in),
        .na_endereco_out     (na_endereco_out),
        .na_ativo_out        (na_ativo_out),
        .livres_out          (livres_out),
        .cheio_out           (cheio_out),
        .vazio_out           (vazio_out),
        .inserido_out        (inserido_out),
        .slot_out            (slot_out),
        .erro_out            (erro_out)
    );

    always #5 clk = ~clk;

    task automatic verificar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    function automatic logic [ADR_WIDTH-1:0] end_slot(input int i);
        return na_endereco_out[i*ADR_WIDTH +: ADR_WIDTH];
    endfunction

    // Apply one request for one clock, then sample 1 time unit after the edge.
    task automatic passo(input logic lim, input logic ins, input logic [ADR_WIDTH-1:0] e,
                         input logic rem, input logic [ADR_WIDTH-1:0] re);
        limpar_in           = lim;
        inserir_in          = ins;
        endereco_in         = e;
        remover_in          = rem;
        remover_endereco_in = re;
        @(posedge clk);
        #1;
        limpar_in  = 1'b0;
        inserir_in = 1'b0;
        remover_in = 1'b0;
    endtask

    task automatic estado(input string tag, input logic [7:0] at, input int liv,
                          input logic ch, input logic vz);
        verificar({tag, ".ativo"},  64'(na_ativo_out), 64'(at));
        verificar({tag, ".livres"}, 64'(livres_out),   64'(liv));
        verificar({tag, ".cheio"},  64'(cheio_out),    64'(ch));
        verificar({tag, ".vazio"},  64'(vazio_out),    64'(vz));
    endtask

    task automatic pulsos(input string tag, input logic ins, input logic err);
        verificar({tag, ".inserido"}, 64'(inserido_out), 64'(ins));
        verificar({tag, ".erro"},     64'(erro_out),     64'(err));
    endtask

    initial begin
        rst = 1'b1;
        limpar_in = 1'b0; inserir_in = 1'b0; endereco_in = '0;
        remover_in = 1'b0; remover_endereco_in = '0;
        repeat (2) @(posedge clk);
        #1;
        estado("reset", 8'h00, 8, 1'b0, 1'b1);
        pulsos("reset", 1'b0, 1'b0);
        verificar("reset.slot", 64'(slot_out), 64'd0);
        verificar("reset.enderecos", 64'(na_endereco_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        passo(0, 1, 5, 0, 0);
        pulsos("ins5", 1, 0);
        verificar("ins5.slot", 64'(slot_out), 64'd0);
        estado("ins5", 8'h01, 7, 0, 0);
        passo(0, 1, 9, 0, 0);
        verificar("ins9.slot", 64'(slot_out), 64'd1);
        pulsos("ins9", 1, 0);
        passo(0, 1, 12, 0, 0);
        verificar("ins12.slot", 64'(slot_out), 64'd2);
        estado("ins12", 8'h07, 5, 0, 0);
        verificar("ins12.s0", 64'(end_slot(0)), 64'd5);
        verificar("ins12.s1", 64'(end_slot(1)), 64'd9);
        verificar("ins12.s2", 64'(end_slot(2)), 64'd12);

        passo(0, 0, 0, 0, 0);
        pulsos("idle", 0, 0);

        passo(0, 1, 9, 0, 0);
        pulsos("dup9", 0, 1);
        estado("dup9", 8'h07, 5, 0, 0);
        verificar("dup9.slot", 64'(slot_out), 64'd2);

        passo(0, 0, 0, 1, 9);
        pulsos("rem9", 0, 0);
        estado("rem9", 8'h05, 6, 0, 0);
        verificar("rem9.s1kept", 64'(end_slot(1)), 64'd9);

        passo(0, 1, 20, 0, 0);
        verificar("ins20.slot", 64'(slot_out), 64'd1);
        verificar("ins20.s1", 64'(end_slot(1)), 64'd20);
        estado("ins20", 8'h07, 5, 0, 0);

        passo(0, 1, 1, 0, 0);
        passo(0, 1, 2, 0, 0);
        passo(0, 1, 3, 0, 0);
        passo(0, 1, 4, 0, 0);
        passo(0, 1, 6, 0, 0);
        verificar("fill.slot", 64'(slot_out), 64'd7);
        estado("fill", 8'hFF, 0, 1, 0);
        verificar("fill.s3", 64'(end_slot(3)), 64'd1);

        passo(0, 1, 7, 0, 0);
        pulsos("full", 0, 1);
        estado("full", 8'hFF, 0, 1, 0);

        passo(0, 1, 31, 1, 1);
        pulsos("swap", 1, 0);
        verificar("swap.slot", 64'(slot_out), 64'd3);
        verificar("swap.s3", 64'(end_slot(3)), 64'd31);
        estado("swap", 8'hFF, 0, 1, 0);

        passo(0, 1, 31, 1, 31);
        pulsos("same", 1, 0);
        verificar("same.slot", 64'(slot_out), 64'd3);
        estado("same", 8'hFF, 0, 1, 0);

        passo(1, 1, 8, 1, 5);
        pulsos("limpar", 0, 0);
        estado("limpar", 8'h00, 8, 0, 1);
        verificar("limpar.s3", 64'(end_slot(3)), 64'd31);
        verificar("limpar.slot", 64'(slot_out), 64'd3);

        passo(0, 1, 10, 0, 0);
        verificar("b2b1.slot", 64'(slot_out), 64'd0);
        passo(0, 1, 10, 0, 0);
        pulsos("b2b2", 0, 1);
        estado("b2b2", 8'h01, 7, 0, 0);

        passo(0, 0, 0, 1, 17);
        pulsos("absent", 0, 0);
        estado("absent", 8'h01, 7, 0, 0);

        passo(0, 1, 11, 0, 0);
        inserir_in = 1'b1;
        endereco_in = 5'd13;
        #2;
        rst = 1'b1;
        #1;
        estado("arst", 8'h00, 8, 0, 1);
        pulsos("arst", 0, 0);
        verificar("arst.slot", 64'(slot_out), 64'd0);
        verificar("arst.enderecos", 64'(na_endereco_out), 64'd0);
        inserir_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        passo(0, 1, 14, 0, 0);
        pulsos("pos", 1, 0);
        verificar("pos.slot", 64'(slot_out), 64'd0);
        verificar("pos.s0", 64'(end_slot(0)), 64'd14);
        estado("pos", 8'h01, 7, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
